// File: rtl/program_loader_pkg.sv
//==============================================================================
// Module  : program_loader_pkg
// Purpose : Shared types and constants for the instruction-memory program loader.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package program_loader_pkg;

    localparam int         INST_W    = 13;
    localparam logic [7:0] RSVD_MASK = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LO    = 3'd1,
        ST_HI    = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/loader_checksum.sv
//==============================================================================
// Module  : loader_checksum
// Purpose : 8-bit modulo-256 running sum of accepted data bytes.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module loader_checksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (add) begin
            sum <= sum + data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
//==============================================================================
// Module  : program_loader
// Purpose : Streams bytes into 13-bit instruction memory while holding the CPU.
//           Optional trailing checksum byte: PROGRAM_LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_last;
    logic [ADDR_W-1:0]   w_last;
    logic                w_xfer;

    // Any length with the top bit set is at least full depth, so it clamps to the last address.
    assign w_last = load_len[ADDR_W] ? {ADDR_W{1'b1}}
                                     : load_len[ADDR_W-1:0] - ADDR_W'(1);

    assign w_xfer = byte_valid && byte_ready;
    assign mem_we = (r_state == ST_WRITE);
    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] w_sum;
    logic       w_accept;
    logic       w_data_xfer;

    assign w_accept    = start && (r_state == ST_IDLE);
    assign w_data_xfer = w_xfer && ((r_state == ST_LO) || (r_state == ST_HI));
    assign byte_ready  = (r_state == ST_LO) || (r_state == ST_HI) || (r_state == ST_CHK);

    loader_checksum u_checksum (
        .clk   (clk),
        .reset (reset),
        .clr   (w_accept),
        .add   (w_data_xfer),
        .data  (byte_data),
        .sum   (w_sum)
    );
`else
    assign byte_ready = (r_state == ST_LO) || (r_state == ST_HI);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_last    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (load_len == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state  <= ST_LO;
                            mem_addr <= '0;
                            r_last   <= w_last;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                ST_LO: begin
                    if (w_xfer) begin
                        mem_wdata[7:0] <= byte_data;
                        r_state        <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (w_xfer) begin
                        mem_wdata[INST_W-1:8] <= byte_data[4:0];
                        if ((byte_data & RSVD_MASK) != 8'h00) begin
                            err <= 1'b1;
                        end
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_addr == r_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_state <= ST_CHK;
`else
                        r_state <= ST_DONE;
`endif
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        r_state  <= ST_LO;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_xfer) begin
                        if (byte_data != w_sum) begin
                            err <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    cpu_hold <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
//==============================================================================
// Module  : tb_program_loader
// Purpose : Scoreboard bench for program_loader against a word-level load model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [12:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  stim[$];
    logic [20:0] exp_wr[$];
    logic        exp_done[$];

    program_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe and every done pulse is matched against the queues.
    always @(negedge clk) begin
        if (mem_we) begin
            check("ready_in_write", 32'(byte_ready), 32'd0);
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
                check("write", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected 0");
            end else begin
                check("err_at_done", 32'(err), 32'(exp_done.pop_front()));
            end
        end
    end

    task automatic gen_words(input int nw);
        logic [7:0] hi;
        for (int i = 0; i < nw; i++) begin
            hi = 8'($urandom);
            if ($urandom_range(0, 3) != 0) hi = hi & 8'h1F;
            stim.push_back(8'($urandom));
            stim.push_back(hi);
        end
    endtask

    task automatic add_csum(input int nw, input logic [7:0] delta);
        logic [7:0] s;
        s = delta;
        for (int i = 0; i < 2 * nw; i++) s = s + stim[i];
        if (CSUM_EN && nw > 0) stim.push_back(s);
    endtask

    task automatic run_load(input int len, input bit gaps, input bit mid_start);
        int         nw;
        int         idx;
        int         t;
        int         sc;
        int         lat;
        logic [7:0] sum;
        logic [7:0] lo;
        logic [7:0] hi;
        bit         e;
        nw  = (len > 256) ? 256 : len;
        e   = 1'b0;
        sum = 8'h00;
        for (int i = 0; i < nw; i++) begin
            lo = stim[2 * i];
            hi = stim[2 * i + 1];
            exp_wr.push_back({8'(i), hi[4:0], lo});
            if (hi[7:5] != 3'b000) e = 1'b1;
            sum = sum + lo + hi;
        end
        lat = (nw == 0) ? 1 : 3 * nw + 1;
        if (CSUM_EN && nw > 0) begin
            if (stim[2 * nw] != sum) e = 1'b1;
            lat++;
        end
        exp_done.push_back(e);

        @(negedge clk);
        start    = 1'b1;
        load_len = 9'(len);
        sc       = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        check("hold_rise", 32'(cpu_hold), 32'(nw != 0));
        check("err_cleared", 32'(err), 32'd0);

        idx = 0;
        t   = 0;
        while (!done && t < 4000) begin
            start = mid_start && (t == 4);
            if (mid_start && t == 4) load_len = 9'd2;
            if (idx < stim.size()) begin
                byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                byte_data  = stim[idx];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end
            if (byte_valid && byte_ready) idx++;
            @(negedge clk);
            t++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
        end else begin
            if (!gaps) check("done_latency", 32'(cyc - sc), 32'(lat));
            if (nw == 0) check("hold_zero_len", 32'(cpu_hold), 32'd0);
        end
        check("bytes_used", 32'(idx), 32'(stim.size()));
        @(negedge clk);
        check("idle_after", 32'({busy, cpu_hold, done}), 32'd0);
        check("err_sticky", 32'(err), 32'(e));
    endtask

    task automatic reset_mid();
        int nwe;
        int t;
        int idx;
        stim.delete();
        gen_words(4);
        for (int i = 0; i < 2; i++) exp_wr.push_back({8'(i), stim[2 * i + 1][4:0], stim[2 * i]});
        @(negedge clk);
        start    = 1'b1;
        load_len = 9'd4;
        @(negedge clk);
        start = 1'b0;
        nwe   = 0;
        t     = 0;
        idx   = 0;
        while (t < 100) begin
            if (mem_we) nwe++;
            if (nwe == 2) break;
            byte_valid = 1'b1;
            byte_data  = stim[idx];
            if (byte_ready) idx++;
            @(negedge clk);
            t++;
        end
        byte_valid = 1'b0;
        if (nwe != 2) begin
            checks++;
            errors++;
            $display("FAIL reset_wait: got %0d writes, expected 2", nwe);
        end
        #2 reset = 1'b0;
        #1 check("reset_outputs",
                 32'({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check("writes_before_reset", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        start      = 1'b0;
        load_len   = 9'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state",
              32'({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err}), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_state", 32'({byte_ready, mem_we, cpu_hold, busy, done, err}), 32'd0);

        stim = '{8'h34, 8'h12, 8'hFF, 8'h1F, 8'h00, 8'h00};
        add_csum(3, 8'h00);
        run_load(3, 1'b0, 1'b0);

        stim = '{8'h34, 8'hE5, 8'h78, 8'h06};
        add_csum(2, 8'h00);
        run_load(2, 1'b0, 1'b0);

        stim.delete();
        gen_words(4);
        add_csum(4, 8'h00);
        run_load(4, 1'b1, 1'b1);

        stim.delete();
        run_load(0, 1'b0, 1'b0);

        reset_mid();

        stim.delete();
        gen_words(1);
        add_csum(1, 8'h00);
        run_load(1, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 12);
            stim.delete();
            gen_words(n);
            add_csum(n, 8'($urandom_range(0, 1)));
            run_load(n, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Oversized length clamps to full depth and ends at the top address.
        stim.delete();
        gen_words(256);
        add_csum(256, 8'h00);
        run_load(300, 1'b0, 1'b0);

        stim = '{8'h01, 8'h00, 8'h02, 8'h00};
        add_csum(2, 8'h00);
        run_load(2, 1'b0, 1'b0);
        stim = '{8'h01, 8'h00, 8'h02, 8'h00};
        add_csum(2, 8'h01);
        run_load(2, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        check("dones_drained", 32'(exp_done.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
